// File: rtl/pulse_seq_pkg.sv
// ----------------------------------------------------------------------------
// pulse_seq_pkg
//   Shared definitions for the pulse sequencer: FSM state type, default
//   counter/time widths and the minimum trigger spacing.
// ----------------------------------------------------------------------------
package pulse_seq_pkg;

  localparam int unsigned CNT_W_DEF  = 32;
  localparam int unsigned TIME_W_DEF = 48;

  // Smallest trigger spacing; guarantees at least one low cycle on the
  // trigger output between consecutive triggers.
  localparam int unsigned STEP_MIN   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ARM  = 2'd2,
    RUN  = 2'd3
  } state_t;

endpackage

// File: rtl/pulse_seq_timer.sv
// ----------------------------------------------------------------------------
// pulse_seq_timer
//   Saturating down-counter used to space triggers. Loading a value N makes
//   o_expired rise N cycles later; a load of 0 reads as expired immediately.
//   The counter stops at zero, so it never wraps.
//
// Ports
//   clk_i      in   1       clock
//   reset_n_i  in   1       synchronous active-low reset
//   i_load     in   1       load i_value on this edge (has priority over count)
//   i_value    in   TIME_W  value to load
//   o_expired  out  1       counter is zero
// ----------------------------------------------------------------------------
module pulse_seq_timer
  import pulse_seq_pkg::*;
#(
  parameter int unsigned TIME_W = TIME_W_DEF
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              i_load,
  input  logic [TIME_W-1:0] i_value,
  output logic              o_expired
);

  logic [TIME_W-1:0] r_count;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - TIME_W'(1);
    end
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/pulse_seq_ctrl.sv
// ----------------------------------------------------------------------------
// pulse_seq_ctrl
//   Sequencer in front of one pulse block. A rising edge on start_i (while
//   enabled and idle) loads DELAY/WIDTH into the pulse block via write
//   strobes, arms it, then issues PULSES single-cycle triggers spaced STEP
//   clocks apart (STEP below 2 is treated as 2). done_o pulses STEP clocks
//   after the last trigger. enable_i low, or a pulse block error while
//   running, aborts the burst; an error abort also sets the sticky err_o.
//
// Optional feature (macro PULSE_SEQ_REPEAT_EN):
//   adds input REPEATS; a completed burst re-enters ARM until REPEATS+1
//   bursts have run. sent_cnt_o restarts per burst; done_o only after the
//   last one.
//
// Ports
//   clk_i           in   1       system clock
//   reset_n_i       in   1       synchronous active-low reset
//   enable_i        in   1       gate; low aborts any burst
//   start_i         in   1       rising edge starts a burst
//   PULSES          in   CNT_W   triggers per burst
//   REPEATS         in   CNT_W   extra bursts (PULSE_SEQ_REPEAT_EN only)
//   STEP            in   TIME_W  clocks between trigger rising edges
//   DELAY_CFG       in   TIME_W  delay to load into pulse block
//   WIDTH_CFG       in   TIME_W  width to load into pulse block
//   err_overflow_i  in   1       pulse block overflow error
//   err_period_i    in   1       pulse block period error
//   pulse_inp_o     out  1       trigger to pulse block input
//   pulse_enable_o  out  1       pulse block enable
//   DELAY_O         out  TIME_W  delay value to pulse block
//   DELAY_WSTB_O    out  1       delay write strobe
//   WIDTH_O         out  TIME_W  width value to pulse block
//   WIDTH_WSTB_O    out  1       width write strobe
//   busy_o          out  1       burst in progress
//   done_o          out  1       1-cycle pulse on normal completion
//   err_o           out  1       sticky abort-on-error flag
//   sent_cnt_o      out  CNT_W   triggers issued in current/last burst
// ----------------------------------------------------------------------------
module pulse_seq_ctrl
  import pulse_seq_pkg::*;
#(
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned TIME_W = TIME_W_DEF
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              enable_i,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  PULSES,
`ifdef PULSE_SEQ_REPEAT_EN
  input  logic [CNT_W-1:0]  REPEATS,
`endif
  input  logic [TIME_W-1:0] STEP,
  input  logic [TIME_W-1:0] DELAY_CFG,
  input  logic [TIME_W-1:0] WIDTH_CFG,
  input  logic              err_overflow_i,
  input  logic              err_period_i,
  output logic              pulse_inp_o,
  output logic              pulse_enable_o,
  output logic [TIME_W-1:0] DELAY_O,
  output logic              DELAY_WSTB_O,
  output logic [TIME_W-1:0] WIDTH_O,
  output logic              WIDTH_WSTB_O,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  sent_cnt_o
);

  state_t            r_state;
  state_t            w_next_state;

  logic              r_start_d;
  logic              r_pulse;
  logic              r_done;
  logic              r_pen;
  logic              r_err;
  logic [CNT_W-1:0]  r_sent;
  logic [TIME_W-1:0] r_delay;
  logic [TIME_W-1:0] r_width;

  logic              w_start_edge;
  logic              w_abort;
  logic              w_err_abort;
  logic              w_kill;
  logic              w_last_burst;
  logic              w_no_pulses;
  logic              w_count_reached;
  logic              w_load_cfg;
  logic              w_fire;
  logic              w_burst_end;
  logic              w_done;
  logic              w_timer_expired;
  logic [TIME_W-1:0] w_step_eff;
  logic [TIME_W-1:0] w_timer_value;

  // --------------------------------------------------------------------------
  // Shared decode
  // --------------------------------------------------------------------------
  assign w_start_edge    = start_i & ~r_start_d;
  assign w_abort         = (r_state != IDLE) & ~enable_i;
  assign w_err_abort     = (r_state == RUN) & (err_overflow_i | err_period_i);
  assign w_kill          = w_abort | w_err_abort;
  assign w_no_pulses     = (PULSES == '0);
  assign w_count_reached = (r_sent >= PULSES);
  assign w_step_eff      = (STEP < TIME_W'(STEP_MIN)) ? TIME_W'(STEP_MIN) : STEP;

  // Triggers are registered, so the timer is reloaded on the decision cycle
  // with STEP-1: the next decision lands STEP-1 cycles later and the next
  // registered trigger exactly STEP cycles after the current one.
  assign w_timer_value   = w_step_eff - TIME_W'(1);

`ifdef PULSE_SEQ_REPEAT_EN
  logic [CNT_W-1:0] r_burst;

  assign w_last_burst = (r_burst >= REPEATS);

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_burst <= '0;
    end else if (w_load_cfg) begin
      r_burst <= '0;
    end else if (w_burst_end && !w_last_burst) begin
      r_burst <= r_burst + CNT_W'(1);
    end
  end
`else
  assign w_last_burst = 1'b1;
`endif

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_start_edge && enable_i) begin
          w_next_state = LOAD;
        end
      end
      LOAD: w_next_state = ARM;
      ARM: begin
        if (w_no_pulses) begin
          w_next_state = w_last_burst ? IDLE : ARM;
        end else begin
          w_next_state = RUN;
        end
      end
      RUN: begin
        if (w_timer_expired && w_count_reached) begin
          w_next_state = w_last_burst ? IDLE : ARM;
        end
      end
      default: w_next_state = IDLE;
    endcase
    if (w_kill) begin
      w_next_state = IDLE;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: outputs and datapath controls
  // --------------------------------------------------------------------------
  always_comb begin
    busy_o       = (r_state != IDLE);
    DELAY_WSTB_O = (r_state == LOAD);
    WIDTH_WSTB_O = (r_state == LOAD);
    w_load_cfg   = 1'b0;
    w_fire       = 1'b0;
    w_burst_end  = 1'b0;
    case (r_state)
      IDLE: w_load_cfg = w_start_edge & enable_i;
      ARM: begin
        if (w_no_pulses) begin
          w_burst_end = 1'b1;
        end else begin
          w_fire = 1'b1;
        end
      end
      RUN: begin
        if (w_timer_expired) begin
          if (w_count_reached) begin
            w_burst_end = 1'b1;
          end else begin
            w_fire = 1'b1;
          end
        end
      end
      default: ;
    endcase
    if (w_kill) begin
      w_fire      = 1'b0;
      w_burst_end = 1'b0;
    end
    w_done = w_burst_end & w_last_burst;
  end

  // --------------------------------------------------------------------------
  // Registered datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_start_d <= 1'b0;
      r_pulse   <= 1'b0;
      r_done    <= 1'b0;
      r_pen     <= 1'b0;
      r_err     <= 1'b0;
      r_sent    <= '0;
      r_delay   <= '0;
      r_width   <= '0;
    end else begin
      r_start_d <= start_i;
      r_pulse   <= w_fire;
      r_done    <= w_done;

      // Config is captured on the way into LOAD so the values are already
      // stable on DELAY_O/WIDTH_O while the strobes are high.
      if (w_load_cfg) begin
        r_delay <= DELAY_CFG;
        r_width <= WIDTH_CFG;
      end

      if (w_load_cfg) begin
        r_sent <= '0;
      end else if (w_fire) begin
        r_sent <= r_sent + CNT_W'(1);
      end else if (w_burst_end && !w_last_burst) begin
        r_sent <= '0;
      end

      if (w_kill) begin
        r_pen <= 1'b0;
      end else if (r_state == LOAD) begin
        r_pen <= 1'b1;
      end

      if (w_load_cfg) begin
        r_err <= 1'b0;
      end else if (w_err_abort) begin
        r_err <= 1'b1;
      end
    end
  end

  pulse_seq_timer #(
    .TIME_W (TIME_W)
  ) u_step_timer (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .i_load    (w_fire),
    .i_value   (w_timer_value),
    .o_expired (w_timer_expired)
  );

  assign pulse_inp_o    = r_pulse;
  assign done_o         = r_done;
  assign pulse_enable_o = r_pen;
  assign err_o          = r_err;
  assign sent_cnt_o     = r_sent;
  assign DELAY_O        = r_delay;
  assign WIDTH_O        = r_width;

endmodule

// File: tb/tb_pulse_seq_ctrl.sv
module tb_pulse_seq_ctrl;

  localparam int unsigned CNT_W  = 32;
  localparam int unsigned TIME_W = 48;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic              enable;
  logic              start;
  logic [CNT_W-1:0]  pulses;
  logic [TIME_W-1:0] step;
  logic [TIME_W-1:0] dly;
  logic [TIME_W-1:0] wid;
  logic              err_ovf;
  logic              err_per;
`ifdef PULSE_SEQ_REPEAT_EN
  logic [CNT_W-1:0]  repeats;
`endif

  logic              pulse_inp_o;
  logic              pulse_enable_o;
  logic [TIME_W-1:0] DELAY_O;
  logic              DELAY_WSTB_O;
  logic [TIME_W-1:0] WIDTH_O;
  logic              WIDTH_WSTB_O;
  logic              busy_o;
  logic              done_o;
  logic              err_o;
  logic [CNT_W-1:0]  sent_cnt_o;

  pulse_seq_ctrl #(
    .CNT_W  (CNT_W),
    .TIME_W (TIME_W)
  ) dut (
    .clk_i          (clk),
    .reset_n_i      (reset_n),
    .enable_i       (enable),
    .start_i        (start),
    .PULSES         (pulses),
`ifdef PULSE_SEQ_REPEAT_EN
    .REPEATS        (repeats),
`endif
    .STEP           (step),
    .DELAY_CFG      (dly),
    .WIDTH_CFG      (wid),
    .err_overflow_i (err_ovf),
    .err_period_i   (err_per),
    .pulse_inp_o    (pulse_inp_o),
    .pulse_enable_o (pulse_enable_o),
    .DELAY_O        (DELAY_O),
    .DELAY_WSTB_O   (DELAY_WSTB_O),
    .WIDTH_O        (WIDTH_O),
    .WIDTH_WSTB_O   (WIDTH_WSTB_O),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_o          (err_o),
    .sent_cnt_o     (sent_cnt_o)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int          cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: a burst is described only by its start cycle and its
  // configuration; every output is a closed-form function of the offset
  // from that start. Aborts freeze the trigger count and end the burst.
  // --------------------------------------------------------------------------
  bit                m_valid = 1'b0;
  bit                m_act   = 1'b0;
  bit                m_pen   = 1'b0;
  bit                m_err   = 1'b0;
  bit                m_prev  = 1'b0;
  int                m_c0    = 0;
  longint            m_P     = 0;
  longint            m_S     = 2;
  longint            m_R     = 0;
  longint            m_hold  = 0;
  logic [TIME_W-1:0] m_dly   = '0;
  logic [TIME_W-1:0] m_wid   = '0;

  always @(negedge clk) begin
    longint rel, q, bend, o, e_sent;
    logic   e_busy, e_wstb, e_done, e_pulse, e_run, e_errin;
    rel = 0; q = 1; bend = 0; o = 0;
    e_sent = m_hold; e_busy = 1'b0; e_wstb = 1'b0; e_done = 1'b0;
    e_pulse = 1'b0; e_run = 1'b0;
    if (m_act) begin
      rel    = longint'(cyc - m_c0);
      q      = m_P * m_S + 1;          // cycles per burst incl. its ARM cycle
      bend   = 1 + (m_R + 1) * q;      // last busy offset
      e_busy = (rel <= bend);
      e_wstb = (rel == 1);
      e_done = (rel == bend + 1);
      if (rel < 2) begin
        e_sent = 0;
      end else if (rel <= bend) begin
        o     = (rel - 2) % q;
        e_run = (o != 0);
        if (o == 0) begin
          e_sent = 0;
        end else begin
          e_sent  = (o - 1) / m_S + 1;
          if (e_sent > m_P) e_sent = m_P;
          e_pulse = ((o - 1) % m_S == 0) && ((o - 1) / m_S < m_P);
        end
      end else begin
        e_sent = m_P;
      end
    end

    if (m_valid) begin
      check("busy",       64'(busy_o),         64'(e_busy));
      check("delay_wstb", 64'(DELAY_WSTB_O),   64'(e_wstb));
      check("width_wstb", 64'(WIDTH_WSTB_O),   64'(e_wstb));
      check("pulse_inp",  64'(pulse_inp_o),    64'(e_pulse));
      check("done",       64'(done_o),         64'(e_done));
      check("pulse_en",   64'(pulse_enable_o), 64'(m_pen));
      check("err",        64'(err_o),          64'(m_err));
      check("sent_cnt",   64'(sent_cnt_o),     64'(e_sent));
      check("delay_o",    64'(DELAY_O),        64'(m_dly));
      check("width_o",    64'(WIDTH_O),        64'(m_wid));
    end

    e_errin = err_ovf | err_per;
    if (!reset_n) begin
      m_valid = 1'b1; m_act = 1'b0; m_pen = 1'b0; m_err = 1'b0;
      m_prev = 1'b0; m_hold = 0; m_dly = '0; m_wid = '0;
    end else if (m_valid) begin
      if (m_act) begin
        if (e_busy && (!enable || (e_errin && e_run))) begin
          m_act  = 1'b0;
          m_hold = e_sent;
          m_pen  = 1'b0;
          if (e_errin && e_run) m_err = 1'b1;
        end else if (e_done) begin
          m_act  = 1'b0;
          m_hold = m_P;
        end else if (rel == 1) begin
          m_pen = 1'b1;
        end
      end
      if (!e_busy && start && !m_prev && enable) begin
        m_act = 1'b1;
        m_c0  = cyc;
        m_P   = longint'(pulses);
        m_S   = (step < 2) ? 2 : longint'(step);
`ifdef PULSE_SEQ_REPEAT_EN
        m_R   = longint'(repeats);
`else
        m_R   = 0;
`endif
        m_dly = dly;
        m_wid = wid;
        m_err = 1'b0;
      end
      m_prev = start;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic step_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic at_cycle(input int n);
    while (cyc < n) step_cycle();
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b1; start = 1'b0;
    err_ovf = 1'b0; err_per = 1'b0;
    pulses  = CNT_W'(3); step = TIME_W'(10);
    dly     = TIME_W'(5); wid = TIME_W'(2);
`ifdef PULSE_SEQ_REPEAT_EN
    repeats = '0;
`endif
    repeat (3) step_cycle();
    reset_n = 1'b1;

    at_cycle(4);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_sent", 64'(sent_cnt_o), 64'd0);
    check("rst_pen",  64'(pulse_enable_o), 64'd0);

    // Burst of 3, STEP 10, start edge in cycle 20
    while (cyc < 20) step_cycle();
    start = 1'b1;
    step_cycle();
    start = 1'b0;
    at_cycle(21);
    check("t1_wstb",  64'(DELAY_WSTB_O), 64'd1);
    check("t1_delay", 64'(DELAY_O), 64'd5);
    check("t1_width", 64'(WIDTH_O), 64'd2);
    at_cycle(23); check("t1_p1", 64'(pulse_inp_o), 64'd1);
    check("t1_sent1", 64'(sent_cnt_o), 64'd1);
    at_cycle(24); check("t1_p1_low", 64'(pulse_inp_o), 64'd0);
    at_cycle(33); check("t1_p2", 64'(pulse_inp_o), 64'd1);
    at_cycle(43); check("t1_p3", 64'(pulse_inp_o), 64'd1);
    at_cycle(52); check("t1_no_done", 64'(done_o), 64'd0);
    at_cycle(53); check("t1_done", 64'(done_o), 64'd1);
    check("t1_sent", 64'(sent_cnt_o), 64'd3);
    at_cycle(54); check("t1_done_low", 64'(done_o), 64'd0);

    // PULSES = 0
    pulses = '0;
    while (cyc < 60) step_cycle();
    start = 1'b1; step_cycle(); start = 1'b0;
    at_cycle(61); check("t2_busy_load", 64'(busy_o), 64'd1);
    at_cycle(62); check("t2_busy_arm",  64'(busy_o), 64'd1);
    at_cycle(63); check("t2_done", 64'(done_o), 64'd1);
    check("t2_idle", 64'(busy_o), 64'd0);

    // STEP = 1 behaves as 2
    pulses = CNT_W'(4); step = TIME_W'(1);
    while (cyc < 70) step_cycle();
    start = 1'b1; step_cycle(); start = 1'b0;
    at_cycle(73); check("t3_p1", 64'(pulse_inp_o), 64'd1);
    at_cycle(74); check("t3_gap", 64'(pulse_inp_o), 64'd0);
    at_cycle(75); check("t3_p2", 64'(pulse_inp_o), 64'd1);
    at_cycle(81); check("t3_done", 64'(done_o), 64'd1);

    // Abort by enable after 2nd of 5 triggers (93, 96)
    pulses = CNT_W'(5); step = TIME_W'(3);
    while (cyc < 90) step_cycle();
    start = 1'b1; step_cycle(); start = 1'b0;
    while (cyc < 97) step_cycle();
    enable = 1'b0;
    step_cycle();
    enable = 1'b1;
    at_cycle(98);
    check("t4_busy", 64'(busy_o), 64'd0);
    check("t4_pen",  64'(pulse_enable_o), 64'd0);
    check("t4_sent", 64'(sent_cnt_o), 64'd2);

    // Error abort, with an ignored start edge while busy
    while (cyc < 110) step_cycle();
    start = 1'b1; step_cycle(); start = 1'b0;
    while (cyc < 114) step_cycle();
    start = 1'b1; step_cycle(); start = 1'b0;
    while (cyc < 117) step_cycle();
    err_per = 1'b1; step_cycle(); err_per = 1'b0;
    at_cycle(118);
    check("t5_err",  64'(err_o), 64'd1);
    check("t5_busy", 64'(busy_o), 64'd0);
    check("t5_sent", 64'(sent_cnt_o), 64'd2);
    at_cycle(125); check("t5_err_sticky", 64'(err_o), 64'd1);

`ifdef PULSE_SEQ_REPEAT_EN
    // 3 bursts of 2 triggers, STEP 4: triggers at offsets 3,7,12,16,21,25
    repeats = CNT_W'(2); pulses = CNT_W'(2); step = TIME_W'(4);
    while (cyc < 140) step_cycle();
    start = 1'b1; step_cycle(); start = 1'b0;
    at_cycle(152); check("t6_p3", 64'(pulse_inp_o), 64'd1);
    at_cycle(161); check("t6_no_done", 64'(done_o), 64'd0);
    at_cycle(165); check("t6_p6", 64'(pulse_inp_o), 64'd1);
    at_cycle(169); check("t6_done", 64'(done_o), 64'd1);
`endif

    // Randomised phase; configuration only changes while no burst is active
    while (cyc < 180) step_cycle();
    for (int i = 0; i < 3000; i++) begin
      step_cycle();
      enable  = ($urandom_range(0, 59) != 0);
      err_ovf = ($urandom_range(0, 79) == 0);
      err_per = ($urandom_range(0, 79) == 0);
      if (!m_act && $urandom_range(0, 3) == 0) begin
        pulses = CNT_W'($urandom_range(0, 5));
        step   = TIME_W'($urandom_range(0, 6));
        dly    = TIME_W'({$urandom(), $urandom()});
        wid    = TIME_W'({$urandom(), $urandom()});
`ifdef PULSE_SEQ_REPEAT_EN
        repeats = CNT_W'($urandom_range(0, 2));
`endif
      end else if ($urandom_range(0, 5) == 0) begin
        start = ~start;
      end
    end
    enable = 1'b1; err_ovf = 1'b0; err_per = 1'b0; start = 1'b0;
    repeat (5) step_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
